perf_counter_bank: RTL and testbench

Multi-channel performance counter unit for the RISC-V pipeline top level. It is the parametrised successor to the single free-running cycle counter. It counts up to NUM_CH independent event streams, such as cycles, retired instructions and stalls, and freezes all channels when the core signals end of program. It snapshots the counts and drives a channel-selectable value onto the on-board seven-segment displays.

---
 rtl/perf_counter_bank.sv | 166 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with a RUN/DONE freeze, channel-selectable display and 7-segment decode.
// Define PERF_SHADOW_EN to build snapshot (shadow) registers and display the shadowed values.
module perf_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int DIGITS   = 6,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      halt,
    input  logic [NUM_CH-1:0]         event_i,
    input  logic                      snap,
    input  logic                      sel_step,
    output logic [$clog2(NUM_CH)-1:0] disp_ch,
    output logic [CNT_W-1:0]          disp_value,
    output logic [7*DIGITS-1:0]       hex,
    output logic [NUM_CH-1:0]         ovf,
    output logic                      done,
    output logic                      state_dbg
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CH_W-1:0]   disp_ch_q, disp_ch_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  disp_value_q, disp_value_d;
    logic [CNT_W-1:0]  disp_src;
    logic              count_en;
    logic              enter_done;

    // The halt cycle itself never counts; clear overrides everything.
    assign count_en   = (state_q == ST_RUN) && !halt && !clear;
    assign enter_done = (state_q == ST_RUN) && halt && !clear;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && halt) begin
            state_d = ST_DONE;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (count_en && event_i[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef PERF_SHADOW_EN
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] shadow_d [NUM_CH];

    // Shadows take cnt_d so a snap captures that cycle's increments too.
    always_comb begin
        shadow_d = shadow_q;
        if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_d[i] = '0;
            end
        end else if (enter_done || snap) begin
            shadow_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign disp_src = shadow_q[disp_ch_q];
`else
    logic unused_snap;
    assign unused_snap = snap;
    assign disp_src    = cnt_q[disp_ch_q];
`endif

    always_comb begin
        sel_d     = sel_step;
        disp_ch_d = disp_ch_q;
        if (sel_step && !sel_q) begin
            disp_ch_d = (disp_ch_q == LAST_CH) ? '0 : disp_ch_q + CH_W'(1);
        end
        disp_value_d = disp_src;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            ovf_q        <= '0;
            disp_ch_q    <= '0;
            sel_q        <= 1'b0;
            disp_value_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ovf_q        <= ovf_d;
            disp_ch_q    <= disp_ch_d;
            sel_q        <= sel_d;
            disp_value_q <= disp_value_d;
            cnt_q        <= cnt_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        hex = '0;
        for (int k = 0; k < DIGITS; k++) begin
            hex[7*k +: 7] = seg7(disp_value_q[4*k +: 4]);
        end
    end

    assign disp_ch    = disp_ch_q;
    assign disp_value = disp_value_q;
    assign ovf        = ovf_q;
    assign done       = (state_q == ST_DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Testbench for perf_counter_bank: a 32-bit main instance plus 8-bit saturating and wrapping instances
// sharing one stimulus stream; expected values are queued and checked by a negedge monitor.
module tb_perf_counter_bank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       clear, halt, snap, sel_step;
    logic [3:0] event_i;

    logic [1:0]  m_disp_ch, s_disp_ch, w_disp_ch;
    logic [31:0] m_disp_value;
    logic [7:0]  s_disp_value, w_disp_value;
    logic [41:0] m_hex;
    logic [13:0] s_hex, w_hex;
    logic [3:0]  m_ovf, s_ovf, w_ovf;
    logic        m_done, s_done, w_done;
    logic        m_state, s_state, w_state;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(32), .DIGITS(6), .SATURATE(1)) u_main (
        .clk(clk), .reset_n(reset_n), .clear(clear), .halt(halt), .event_i(event_i),
        .snap(snap), .sel_step(sel_step), .disp_ch(m_disp_ch), .disp_value(m_disp_value),
        .hex(m_hex), .ovf(m_ovf), .done(m_done), .state_dbg(m_state)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .DIGITS(2), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .halt(halt), .event_i(event_i),
        .snap(snap), .sel_step(sel_step), .disp_ch(s_disp_ch), .disp_value(s_disp_value),
        .hex(s_hex), .ovf(s_ovf), .done(s_done), .state_dbg(s_state)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .DIGITS(2), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .halt(halt), .event_i(event_i),
        .snap(snap), .sel_step(sel_step), .disp_ch(w_disp_ch), .disp_value(w_disp_value),
        .hex(w_hex), .ovf(w_ovf), .done(w_done), .state_dbg(w_state)
    );

    // Scoreboard
    logic [63:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam int S_M_VAL = 0, S_M_CH = 1, S_M_DONE = 2, S_M_OVF = 3, S_M_HEX0 = 4,
                   S_S_VAL = 5, S_S_OVF = 6, S_W_VAL = 7, S_W_OVF = 8, S_M_STATE = 9,
                   S_M_HEX = 10, S_S_HEX = 11;

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            S_M_VAL:   pick = 64'(m_disp_value);
            S_M_CH:    pick = 64'(m_disp_ch);
            S_M_DONE:  pick = 64'(m_done);
            S_M_OVF:   pick = 64'(m_ovf);
            S_M_HEX0:  pick = 64'(m_hex[6:0]);
            S_S_VAL:   pick = 64'(s_disp_value);
            S_S_OVF:   pick = 64'(s_ovf);
            S_W_VAL:   pick = 64'(w_disp_value);
            S_W_OVF:   pick = 64'(w_ovf);
            S_M_STATE: pick = 64'(m_state);
            S_M_HEX:   pick = 64'(m_hex);
            S_S_HEX:   pick = 64'(s_hex);
            default:   pick = '1;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [63:0] v);
        name_q.push_back(name);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            automatic string       nm  = name_q.pop_front();
            automatic int          sel = sel_q.pop_front();
            automatic logic [63:0] e   = exp_q.pop_front();
            automatic logic [63:0] a   = pick(sel);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
            end
        end
    end

    // Driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel();
        sel_step = 1'b1;
        tick();
        sel_step = 1'b0;
        tick();
    endtask

    localparam logic [41:0] HEX_ZERO6 = {6{7'b1000000}};
    localparam logic [13:0] HEX_ZERO2 = {2{7'b1000000}};
    // 300 = 0x00012C
    localparam logic [41:0] HEX_300 = {7'b1000000, 7'b1000000, 7'b1000000,
                                       7'b1111001, 7'b0100100, 7'b1000110};

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        halt     = 1'b0;
        snap     = 1'b0;
        sel_step = 1'b0;
        event_i  = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;

        expect_val("reset_disp_value", S_M_VAL, 0);
        expect_val("reset_disp_ch", S_M_CH, 0);
        expect_val("reset_done", S_M_DONE, 0);
        expect_val("reset_ovf", S_M_OVF, 0);
        expect_val("reset_hex", S_M_HEX, 64'(HEX_ZERO6));
        expect_val("reset_state", S_M_STATE, 0);
        expect_val("reset_sat_hex", S_S_HEX, 64'(HEX_ZERO2));
        tick();

        // Ten events on channel 0, then halt with the event still high.
        event_i = 4'b0001;
        repeat (10) tick();
        expect_val("pre_halt_done", S_M_DONE, 0);
`ifndef PERF_SHADOW_EN
        expect_val("live_lags_one", S_M_VAL, 9);
`endif
        halt = 1'b1;
        tick();
        expect_val("halt_done_rise", S_M_DONE, 1);
        expect_val("halt_state_done", S_M_STATE, 1);
        halt    = 1'b0;
        event_i = 4'b1111;
        tick();
        expect_val("done_value_10", S_M_VAL, 10);
        expect_val("done_hex0_A", S_M_HEX0, 64'(7'b0001000));
        repeat (4) tick();
        expect_val("frozen_value", S_M_VAL, 10);
        expect_val("frozen_done", S_M_DONE, 1);
        expect_val("frozen_ovf", S_M_OVF, 0);

        // clear together with halt while in DONE.
        clear = 1'b1;
        halt  = 1'b1;
        tick();
        expect_val("clr_done_low", S_M_DONE, 0);
        expect_val("clr_state_run", S_M_STATE, 0);
        expect_val("clr_ovf", S_M_OVF, 0);
        expect_val("clr_disp_ch_kept", S_M_CH, 0);
        clear   = 1'b0;
        halt    = 1'b0;
        event_i = 4'b0000;
        tick();
        expect_val("clr_value_zero", S_M_VAL, 0);

        // Held sel_step advances once; then four separate pulses.
        sel_step = 1'b1;
        tick();
        expect_val("sel_first_edge", S_M_CH, 1);
        repeat (4) tick();
        expect_val("sel_held_no_repeat", S_M_CH, 1);
        sel_step = 1'b0;
        tick();
        pulse_sel();
        expect_val("sel_pulse1", S_M_CH, 2);
        pulse_sel();
        expect_val("sel_pulse2", S_M_CH, 3);
        pulse_sel();
        expect_val("sel_pulse3_wrap", S_M_CH, 0);
        pulse_sel();
        expect_val("sel_pulse4", S_M_CH, 1);

        // 300 events on channel 1 into the 32-bit, saturating and wrapping instances.
        event_i = 4'b0010;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 255) begin
                expect_val("sat_ovf_before", S_S_OVF, 0);
                expect_val("wrap_ovf_before", S_W_OVF, 0);
`ifndef PERF_SHADOW_EN
                expect_val("wrap_val_254", S_W_VAL, 254);
`endif
            end
            if (k == 256) begin
                expect_val("sat_ovf_set", S_S_OVF, 4'b0010);
                expect_val("wrap_ovf_set", S_W_OVF, 4'b0010);
`ifndef PERF_SHADOW_EN
                expect_val("sat_val_255", S_S_VAL, 255);
`endif
            end
            if (k == 257) begin
`ifndef PERF_SHADOW_EN
                expect_val("wrap_val_0", S_W_VAL, 0);
                expect_val("sat_val_held", S_S_VAL, 255);
`endif
                expect_val("main_ovf_clear", S_M_OVF, 0);
            end
        end
        event_i = 4'b0000;
        snap    = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        expect_val("main_val_300", S_M_VAL, 300);
        expect_val("main_hex_300", S_M_HEX, 64'(HEX_300));
        expect_val("sat_final_255", S_S_VAL, 255);
        expect_val("wrap_final_44", S_W_VAL, 44);
        expect_val("sat_ovf_sticky", S_S_OVF, 4'b0010);
        expect_val("wrap_ovf_sticky", S_W_OVF, 4'b0010);

        // Snap coinciding with an event on channel 2.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_val("clr_sat_ovf", S_S_OVF, 0);
        pulse_sel();
        expect_val("sel_to_ch2", S_M_CH, 2);
        event_i = 4'b0100;
        repeat (7) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (3) tick();
        event_i = 4'b0000;
        tick();
        tick();
`ifdef PERF_SHADOW_EN
        expect_val("snap_shadow_8", S_M_VAL, 8);
`else
        expect_val("snap_ignored_live_11", S_M_VAL, 11);
`endif

        // Asynchronous reset between edges while counting.
        event_i = 4'b1111;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        expect_val("async_value", S_M_VAL, 0);
        expect_val("async_disp_ch", S_M_CH, 0);
        expect_val("async_hex", S_M_HEX, 64'(HEX_ZERO6));
        expect_val("async_ovf", S_M_OVF, 0);
        expect_val("async_done", S_M_DONE, 0);
        tick();
        event_i = 4'b0000;
        reset_n = 1'b1;
        tick();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
